// File: rtl/network_source.sv
// Inbound dispatch decoder: turns RUN/CLR/SPK/SNC packets into network
// timestep enables, input spikes, network reset pulses and sync requests.
module network_source #(
  parameter int PKT_WIDTH = 16,
  localparam int NUM_OPC = 8,
  localparam int NUM_INP = 6,
  localparam int PFX_WIDTH = $clog2(NUM_OPC),
  localparam int SPK_WIDTH = $clog2(NUM_INP),
  localparam int RUN_WIDTH = PKT_WIDTH - PFX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [PKT_WIDTH-1:0] src,
  input  logic                 net_ready,
  output logic                 net_arstn,
  output logic                 net_en,
  output logic [NUM_INP-1:0]   net_inp,
  output logic                 net_sync,
  output logic                 err
);

  localparam logic [PFX_WIDTH-1:0] OPC_RUN = PFX_WIDTH'(0);
  localparam logic [PFX_WIDTH-1:0] OPC_CLR = PFX_WIDTH'(1);
  localparam logic [PFX_WIDTH-1:0] OPC_SPK = PFX_WIDTH'(2);
  localparam logic [PFX_WIDTH-1:0] OPC_SNC = PFX_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, RUNS, CLRD, SYNC} state_t;

  state_t               state_reg, state_next;
  logic [NUM_INP-1:0]   acc_reg, acc_next;
  logic [RUN_WIDTH-1:0] runs_reg, runs_next;
  logic                 err_reg, err_next;

  logic [PFX_WIDTH-1:0] opc;
  logic [RUN_WIDTH-1:0] payload;
  logic [SPK_WIDTH-1:0] idx;

  assign opc     = src[PKT_WIDTH-1 -: PFX_WIDTH];
  assign payload = src[RUN_WIDTH-1:0];
  assign idx     = src[RUN_WIDTH-1 -: SPK_WIDTH];
  assign err     = err_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    runs_next  = runs_reg;
    err_next   = err_reg;
    src_ready  = (state_reg == IDLE) && !rst;
    net_en     = 1'b0;
    net_sync   = 1'b0;
    net_arstn  = !rst;
    net_inp    = '0;
    case (state_reg)
      IDLE: begin
        if (src_valid && src_ready) begin
          case (opc)
            OPC_SPK: begin
              if (int'(idx) >= NUM_INP) err_next = 1'b1;
              else acc_next[idx] = 1'b1;
            end
            OPC_RUN: begin
              runs_next = payload;
              if (payload != '0) state_next = RUNS;
            end
            OPC_CLR: begin
              acc_next   = '0;
              state_next = CLRD;
            end
            OPC_SNC: state_next = SYNC;
            default: err_next = 1'b1;
          endcase
        end
      end
      RUNS: begin
        net_en = net_ready && !rst;
        if (net_en) begin
          // Spikes belong to the first timestep of a run only.
          net_inp   = acc_reg;
          acc_next  = '0;
          runs_next = runs_reg - RUN_WIDTH'(1);
          if (runs_reg == RUN_WIDTH'(1)) state_next = IDLE;
        end
      end
      CLRD: begin
        net_arstn  = 1'b0;
        state_next = IDLE;
      end
      SYNC: begin
        net_sync = net_ready && !rst;
        if (net_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      runs_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      runs_reg  <= runs_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_network_source.sv
// Bench for network_source: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_network_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [15:0] src = '0;
  logic        net_ready = 1'b0;
  logic        net_arstn;
  logic        net_en;
  logic [5:0]  net_inp;
  logic        net_sync;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model: pending work expressed as plain counters and flags.
  bit [5:0] m_spk;
  int       m_runs;
  bit       m_clr, m_snc, m_err;

  network_source #(.PKT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src(src), .net_ready(net_ready), .net_arstn(net_arstn), .net_en(net_en),
    .net_inp(net_inp), .net_sync(net_sync), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] pkt(input logic [2:0] opc, input logic [12:0] pay);
    return {opc, pay};
  endfunction

  function automatic logic [15:0] spk(input logic [2:0] idx);
    return {3'd2, idx, 10'd0};
  endfunction

  task automatic step(input bit v, input logic [15:0] p, input bit rdy, input bit r,
                      output bit accepted, output bit en_seen);
    bit       e_ready, e_en, e_sync, e_arstn, busy;
    bit [5:0] e_inp;
    bit [2:0] opc, idx;
    src_valid = v;
    src       = p;
    net_ready = rdy;
    rst       = r;
    @(negedge clk);
    busy    = (m_runs > 0) || m_clr || m_snc;
    e_ready = !r && !busy;
    e_en    = !r && (m_runs > 0) && rdy;
    e_inp   = e_en ? m_spk : 6'd0;
    e_sync  = !r && m_snc && rdy;
    e_arstn = !(r || m_clr);
    check("src_ready", 32'(src_ready), 32'(e_ready));
    check("net_en",    32'(net_en),    32'(e_en));
    check("net_inp",   32'(net_inp),   32'(e_inp));
    check("net_sync",  32'(net_sync),  32'(e_sync));
    check("net_arstn", 32'(net_arstn), 32'(e_arstn));
    check("err",       32'(err),       32'(m_err));
    accepted = v && e_ready;
    en_seen  = net_en;
    if (r) begin
      m_spk = '0; m_runs = 0; m_clr = 0; m_snc = 0; m_err = 0;
    end else if (m_runs > 0) begin
      if (rdy) begin
        m_runs--;
        m_spk = '0;
      end
    end else if (m_clr) begin
      m_clr = 0;
    end else if (m_snc) begin
      if (rdy) m_snc = 0;
    end else if (accepted) begin
      opc = p[15:13];
      idx = p[12:10];
      $display("pkt opc=%0d payload=%0h", opc, p[12:0]);
      case (opc)
        3'd2: if (idx < 6) m_spk[idx] = 1'b1; else m_err = 1'b1;
        3'd0: m_runs = int'(p[12:0]);
        3'd1: begin m_spk = '0; m_clr = 1; end
        3'd3: m_snc = 1;
        default: m_err = 1'b1;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p, input bit rdy);
    bit a, e;
    a = 0;
    for (int i = 0; i < 50 && !a; i++) step(1'b1, p, rdy, 1'b0, a, e);
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit rdy, output int pulses);
    bit a, e;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 16'd0, rdy, 1'b0, a, e);
      if (e) pulses++;
    end
  endtask

  initial begin
    bit a, e, have;
    int pulses;
    logic [15:0] cur;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    m_spk = '0; m_runs = 0; m_clr = 0; m_snc = 0; m_err = 0;

    step(1'b0, 16'd0, 1'b1, 1'b1, a, e);
    step(1'b0, 16'd0, 1'b1, 1'b1, a, e);
    idle(2, 1'b1, pulses);

    // Spikes on first timestep only
    send(spk(3'd2), 1'b1);
    send(spk(3'd5), 1'b1);
    send(pkt(3'd0, 13'd3), 1'b1);
    idle(5, 1'b1, pulses);
    check("run3_pulses", 32'(pulses), 32'd3);

    // Stalls on net_ready
    send(pkt(3'd0, 13'd4), 1'b1);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 16'd0, pat[i], 1'b0, a, e);
      if (e) pulses++;
    end
    check("run4_pulses", 32'(pulses), 32'd4);
    idle(2, 1'b1, pulses);

    // Clear drops pending spikes
    send(spk(3'd1), 1'b1);
    send(pkt(3'd1, 13'd0), 1'b1);
    send(pkt(3'd0, 13'd1), 1'b1);
    idle(3, 1'b1, pulses);

    // Sync waits for net_ready
    send(pkt(3'd3, 13'd0), 1'b0);
    idle(5, 1'b0, pulses);
    idle(3, 1'b1, pulses);

    // Error cases
    send(spk(3'd6), 1'b1);
    send(pkt(3'd5, 13'h123), 1'b1);
    send(pkt(3'd0, 13'd0), 1'b1);
    idle(3, 1'b1, pulses);

    // Reset mid-run
    send(pkt(3'd0, 13'd10), 1'b1);
    idle(2, 1'b1, pulses);
    step(1'b0, 16'd0, 1'b1, 1'b1, a, e);
    step(1'b0, 16'd0, 1'b1, 1'b1, a, e);
    idle(1, 1'b1, pulses);
    send(pkt(3'd0, 13'd1), 1'b1);
    idle(4, 1'b1, pulses);
    check("post_rst_pulses", 32'(pulses), 32'd1);

    // Maximum run count does not wrap
    send(spk(3'd0), 1'b1);
    send(pkt(3'd0, 13'h1FFF), 1'b1);
    idle(8200, 1'b1, pulses);
    check("max_run_pulses", 32'(pulses), 32'd8191);

    // Random traffic; a packet is held until accepted
    have = 0;
    cur  = '0;
    for (int i = 0; i < 4000; i++) begin
      bit r, rdy;
      if (!have && ($urandom % 4 != 0)) begin
        case ($urandom_range(0, 7))
          0, 1, 2: cur = spk(3'($urandom_range(0, 7)));
          3, 4:    cur = pkt(3'd0, 13'($urandom_range(0, 5)));
          5:       cur = pkt(3'd1, 13'($urandom));
          6:       cur = pkt(3'd3, 13'($urandom));
          default: cur = pkt(3'($urandom_range(4, 7)), 13'($urandom));
        endcase
        have = 1;
      end
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom % 3 != 0);
      step(have, cur, rdy, r, a, e);
      if (a) have = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
